// File: rtl/ccg_response_compactor_if.sv
// ----------------------------------------------------------------------------
// Module   : ccg_response_compactor_if
// Purpose  : Vector sink and run-control/result bundle for the response compactor.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface ccg_response_compactor_if #(
  parameter int unsigned IN_W  = 22,
  parameter int unsigned SIG_W = 32,
  parameter int unsigned CNT_W = 17
);
  logic             start;
  logic [CNT_W-1:0] num_vec;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             busy;
  logic             done;
  logic [SIG_W-1:0] signature;
  logic [CNT_W-1:0] vec_count;

  // Master is the pattern source / test controller side.
  modport master (
    output start, num_vec, in_valid, in_data,
    input  in_ready, busy, done, signature, vec_count
  );

  modport slave (
    input  start, num_vec, in_valid, in_data,
    output in_ready, busy, done, signature, vec_count
  );
endinterface

`default_nettype wire

// File: rtl/ccg_response_compactor.sv
// ----------------------------------------------------------------------------
// Module   : ccg_response_compactor
// Purpose  : Folds a fixed number of circuit output vectors into a MISR signature.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module ccg_response_compactor #(
  parameter int unsigned          IN_W  = 22,
  parameter int unsigned          SIG_W = 32,
  parameter logic [SIG_W-1:0]     POLY  = SIG_W'(32'h04C11DB7),
  parameter logic [SIG_W-1:0]     SEED  = SIG_W'(32'hFFFFFFFF),
  parameter int unsigned          CNT_W = 17
) (
  input  wire                      clk,
  input  wire                      rst_n,
  ccg_response_compactor_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [SIG_W-1:0] sig_q,   sig_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [CNT_W-1:0] num_q,   num_d;

  logic             accept;
  logic [CNT_W-1:0] cnt_inc;
  logic [SIG_W-1:0] sig_next;

  // in_ready comes from the state register only, so accept never loops back.
  assign accept   = bus.in_valid && (state_q == ST_RUN);
  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign sig_next = {sig_q[SIG_W-2:0], 1'b0}
                  ^ (sig_q[SIG_W-1] ? POLY : '0)
                  ^ SIG_W'(bus.in_data);

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          sig_d   = SEED;
          cnt_d   = '0;
          num_d   = bus.num_vec;
          state_d = (bus.num_vec == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept) begin
          sig_d = sig_next;
          cnt_d = cnt_inc;
          if (cnt_inc == num_q) begin
            state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sig_q   <= '0;
      cnt_q   <= '0;
      num_q   <= '0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_RUN);
  assign bus.busy      = (state_q == ST_RUN);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.signature = sig_q;
  assign bus.vec_count = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_ccg_response_compactor.sv
// ----------------------------------------------------------------------------
// Module   : tb_ccg_response_compactor
// Purpose  : Directed self-checking bench for ccg_response_compactor.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ccg_response_compactor;

  localparam int unsigned c_in_w  = 22;
  localparam int unsigned c_sig_w = 32;
  localparam int unsigned c_cnt_w = 17;

  localparam logic [31:0] c_seed    = 32'hFFFFFFFF;
  localparam logic [31:0] c_sig_z1  = 32'hFB3EE249;
  localparam logic [31:0] c_sig_z2  = 32'hF2BCD925;
  localparam logic [31:0] c_sig_one = 32'hFB011DB6;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_fail;

  ccg_response_compactor_if #(
    .IN_W (c_in_w),
    .SIG_W(c_sig_w),
    .CNT_W(c_cnt_w)
  ) bus ();

  ccg_response_compactor #(
    .IN_W (c_in_w),
    .SIG_W(c_sig_w),
    .CNT_W(c_cnt_w)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [c_cnt_w-1:0] n);
    bus.num_vec = n;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
  endtask

  // Waits (bounded) for in_ready, then presents one vector for exactly one edge.
  task automatic send(input logic [c_in_w-1:0] d);
    int waited;
    waited = 0;
    while (!bus.in_ready && waited < 20) begin
      tick();
      waited++;
    end
    check_eq("in_ready_wait", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b1;
    bus.num_vec  = 17'd5;
    bus.in_valid = 1'b1;
    bus.in_data  = 22'h3FFFFF;

    // Reset held while inputs toggle
    repeat (3) tick();
    check_eq("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check_eq("rst_done",     64'(bus.done),     64'd0);
    check_eq("rst_busy",     64'(bus.busy),     64'd0);
    check_eq("rst_sig",      64'(bus.signature), 64'h0);
    check_eq("rst_cnt",      64'(bus.vec_count), 64'd0);

    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    rst_n        = 1'b1;
    repeat (2) tick();
    check_eq("idle_in_ready", 64'(bus.in_ready), 64'd0);
    check_eq("idle_busy",     64'(bus.busy),     64'd0);
    check_eq("idle_done",     64'(bus.done),     64'd0);

    // Single zero vector
    do_start(17'd1);
    check_eq("t1_ready_after_start", 64'(bus.in_ready), 64'd1);
    check_eq("t1_busy",              64'(bus.busy),     64'd1);
    check_eq("t1_seed",              64'(bus.signature), 64'(c_seed));
    send('0);
    check_eq("t1_sig",      64'(bus.signature), 64'(c_sig_z1));
    check_eq("t1_cnt",      64'(bus.vec_count), 64'd1);
    check_eq("t1_done",     64'(bus.done),      64'd1);
    check_eq("t1_in_ready", 64'(bus.in_ready),  64'd0);

    // Two zero vectors back-to-back, restart from DONE
    do_start(17'd2);
    check_eq("t2_done_drop", 64'(bus.done),      64'd0);
    check_eq("t2_seed",      64'(bus.signature), 64'(c_seed));
    check_eq("t2_cnt0",      64'(bus.vec_count), 64'd0);
    send('0);
    check_eq("t2_sig1",  64'(bus.signature), 64'(c_sig_z1));
    check_eq("t2_done1", 64'(bus.done),      64'd0);
    send('0);
    check_eq("t2_sig2", 64'(bus.signature), 64'(c_sig_z2));
    check_eq("t2_cnt2", 64'(bus.vec_count), 64'd2);
    check_eq("t2_done", 64'(bus.done),      64'd1);
    check_eq("t2_busy", 64'(bus.busy),      64'd0);

    // In DONE, in_data is ignored
    bus.in_valid = 1'b1;
    bus.in_data  = 22'h12345;
    repeat (2) tick();
    bus.in_valid = 1'b0;
    check_eq("done_frozen_sig", 64'(bus.signature), 64'(c_sig_z2));
    check_eq("done_frozen_cnt", 64'(bus.vec_count), 64'd2);

    // All-ones vector
    do_start(17'd1);
    send(22'h3FFFFF);
    check_eq("t3_sig",  64'(bus.signature), 64'(c_sig_one));
    check_eq("t3_done", 64'(bus.done),      64'd1);

    // Stall gap between two vectors
    do_start(17'd2);
    send('0);
    bus.in_data = 22'h2AAAAA;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("gap_sig", 64'(bus.signature), 64'(c_sig_z1));
      check_eq("gap_cnt", 64'(bus.vec_count), 64'd1);
    end
    send('0);
    check_eq("gap_final_sig", 64'(bus.signature), 64'(c_sig_z2));
    check_eq("gap_final_cnt", 64'(bus.vec_count), 64'd2);
    check_eq("gap_done",      64'(bus.done),      64'd1);

    // Zero-length run
    do_start(17'd0);
    check_eq("zl_done",     64'(bus.done),      64'd1);
    check_eq("zl_sig",      64'(bus.signature), 64'(c_seed));
    check_eq("zl_cnt",      64'(bus.vec_count), 64'd0);
    check_eq("zl_in_ready", 64'(bus.in_ready),  64'd0);

    // Start coinciding with the final accept is ignored
    do_start(17'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = '0;
    bus.start    = 1'b1;
    bus.num_vec  = 17'd2;
    tick();
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    check_eq("coinc_done", 64'(bus.done),      64'd1);
    check_eq("coinc_sig",  64'(bus.signature), 64'(c_sig_z1));
    tick();
    check_eq("coinc_still_done", 64'(bus.done), 64'd1);

    // Start during RUN ignored, then asynchronous abort
    do_start(17'd3);
    send('0);
    bus.num_vec = 17'd1;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
    check_eq("run_start_cnt",  64'(bus.vec_count), 64'd1);
    check_eq("run_start_sig",  64'(bus.signature), 64'(c_sig_z1));
    check_eq("run_start_busy", 64'(bus.busy),      64'd1);
    send('0);
    check_eq("run_keep_num_busy", 64'(bus.busy),      64'd1);
    check_eq("run_keep_num_cnt",  64'(bus.vec_count), 64'd2);

    #2;
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy",     64'(bus.busy),      64'd0);
    check_eq("abort_in_ready", 64'(bus.in_ready),  64'd0);
    check_eq("abort_done",     64'(bus.done),      64'd0);
    check_eq("abort_sig",      64'(bus.signature), 64'h0);
    check_eq("abort_cnt",      64'(bus.vec_count), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("post_abort_idle", 64'(bus.in_ready), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
